alu_share_arb: RTL and testbench
================================

# alu_share_arb

Two-port arbiter and sequencer that shares the single-cycle 32-bit ALU between two requesters, e.g. the execute stage (port 0) and the branch-compare unit (port 1). Each port issues operations over a valid/ready request channel and receives the registered result and zero flag over a valid/ready response channel. The block drives the ALU operand and control inputs directly and samples its combinational result and zero flag. There is one operation in flight at a time, and ports are granted round-robin.

## Interface
- `DW`, default 32: operand/result width; must equal the ALU width.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid[1:0]`  in  2  per-port request valid.
- `req_ready[1:0]`  out  2  per-port request ready (at most one bit set).
- `req_op0`, `req_op1`  in  3  ALU control code: 010 ADD, 110 SUB, 000 AND, 001 OR, 111 SLT.
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  in  DW  operands per port.
- `rsp_valid[1:0]`  out  2  per-port response valid.
- `rsp_ready[1:0]`  in  2  per-port response ready.
- `rsp_result`  out  DW  result; shared bus, meaningful for the port with `rsp_valid` set.
- `rsp_zero`  out  1  zero flag paired with `rsp_result`.
- `alu_srcA`, `alu_srcB`  out  DW  ALU operands.
- `alu_control`  out  3  ALU control.
- `alu_result`  in  DW  ALU result (combinational from the `alu_*` outputs).
- `alu_zero`  in  1  ALU zero flag.

## Operation
- FSM states: IDLE, EXEC, HOLD.
- **IDLE**
  - `req_ready[g]=1` only for the granted port g. No grant means no ready.
  - On `req_valid[g]&req_ready[g]`: capture op, a and b into operand registers; record owner=g; update last-grant pointer to g; go to EXEC.
- **EXEC**
  - Operand registers drive `alu_srcA`, `alu_srcB` and `alu_control`.
  - At the clock edge, capture `alu_result` and `alu_zero` into the response registers and go to HOLD.
- **HOLD**
  - `rsp_valid[owner]=1`, and the other bit is 0.
  - On `rsp_ready[owner]`, go to IDLE.
  - Result and zero stay stable until the handshake completes.
- **Grant rule (round-robin)**
  - If only one `req_valid` bit is set, that port is granted.
  - If both are set, grant the port not equal to the last-grant pointer.
  - The last-grant pointer resets to 1, so port 0 wins the first tie.
- Request rules:
  - `req_valid` must not depend on `req_ready`.
  - Once raised, valid and payload hold until accepted.
  - A port may drop a request only before acceptance.
- Opcodes 011, 100 and 101 are forwarded unchanged. The ALU returns result 0, zero=1, and this is passed through; no error signalling.
- SLT is unsigned compare per ALU behaviour. The arbiter does no arithmetic and no width conversion.
- `alu_*` outputs hold the last operand register values outside EXEC.
- Reset values (asynchronous, independent of clk):
  - state=IDLE, owner=0, pointer=1.
  - `req_ready`=00, `rsp_valid`=00.
  - `rsp_result`=0, `rsp_zero`=0.
  - `alu_srcA`=0, `alu_srcB`=0, `alu_control`=000.
- Reset mid-operation: an in-flight request or pending response is discarded. No response is produced after reset release.

## Timing
- Accept at edge N. EXEC occupies cycle N..N+1 and the ALU is sampled at edge N+1. `rsp_valid` is high from edge N+1, so it is visible in cycle N+1. Request-to-response latency is 1 cycle after acceptance.
- If `rsp_ready` is already high, the response completes at edge N+2. IDLE then re-grants in the following cycle.
- Peak throughput is 1 operation per 3 cycles.
- `req_ready` is combinational from state, `req_valid` and the pointer; no combinational path from `rsp_ready`.
- `rsp_valid`, `rsp_result` and `rsp_zero` are registered.
- A request raised while the block is in EXEC or HOLD waits. Arbitration is evaluated fresh in each IDLE cycle.
- Back-pressure: a stalled `rsp_ready` holds HOLD indefinitely, and both request ports see ready=0.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined:
  - Port 0 always wins when both ports request.
  - The last-grant pointer is not implemented.
  - Port 1 may starve.
- Undefined (default): round-robin as above.

## Test plan
- **Single ADD:** port 0 sends op=010, a=7, b=5. Expect `req_ready[0]` in IDLE, `rsp_valid`=01 one cycle after accept, result=12, zero=0.
- **SUB to zero:** port 1 sends op=110, a=9, b=9. Expect `rsp_valid`=10, result=0, zero=1.
- **Simultaneous persistent requests:** port 0 ADD 1+1, port 1 OR 4|2. Expect grants in order 0,1,0,1 (round-robin). Expect results 2 and 6 on the matching `rsp_valid` bits. With `ALU_ARB_FIXED_PRIO_EN`, expect port 0 granted every time.
- **Response back-pressure:** SLT a=3, b=8 with `rsp_ready[0]=0` for 5 cycles. Expect result=1 stable and `rsp_valid[0]` held. Expect `req_ready` stays 00 despite port 1 requesting. Port 1 is granted in the first IDLE cycle after release.
- **Reset in EXEC:** assert `rst_n=0` during EXEC. Expect immediate `rsp_valid`=00, `req_ready`=00 and all `alu_*` outputs 0, with no response after release.
- **Illegal opcode:** op=101 with any operands. Expect result=0, zero=1, normal handshake.

Source files
------------

// File: rtl/alu_share_arb.sv
// ----------------------------------------------------------------------------
// alu_share_arb
//
// Shares one single-cycle ALU between two requesters (port 0: execute stage,
// port 1: branch-compare unit). One operation is in flight at a time. Each
// operation takes three cycles: accept (IDLE), ALU evaluate (EXEC), and
// response handshake (HOLD).
//
// Configuration macro:
//   ALU_ARB_FIXED_PRIO_EN  defined   : port 0 always wins a tie, so port 1
//                                      may starve; no last-grant pointer.
//                          undefined : round-robin on ties. The pointer
//                                      resets to 1, so port 0 wins the first
//                                      tie.
//
// Parameters:
//   DW              operand/result width, must equal the ALU width.
//
// Ports:
//   i_clk           clock, all state updates on the rising edge
//   i_rst_n         asynchronous active-low reset
//   i_req_valid[1:0]  per-port request valid
//   o_req_ready[1:0]  per-port request ready, at most one bit set
//   i_req_op0/1     ALU control code per port
//   i_req_a0/b0     port 0 operands
//   i_req_a1/b1     port 1 operands
//   o_rsp_valid[1:0]  per-port response valid (registered)
//   i_rsp_ready[1:0]  per-port response ready
//   o_rsp_result    shared result bus (registered)
//   o_rsp_zero      zero flag paired with o_rsp_result (registered)
//   o_alu_srcA/B    ALU operands
//   o_alu_control   ALU control code
//   i_alu_result    ALU result, combinational from the o_alu_* outputs
//   i_alu_zero      ALU zero flag
// ----------------------------------------------------------------------------
module alu_share_arb #(
  parameter int unsigned DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  // Request channel
  input  logic [1:0]    i_req_valid,
  output logic [1:0]    o_req_ready,
  input  logic [2:0]    i_req_op0,
  input  logic [2:0]    i_req_op1,
  input  logic [DW-1:0] i_req_a0,
  input  logic [DW-1:0] i_req_b0,
  input  logic [DW-1:0] i_req_a1,
  input  logic [DW-1:0] i_req_b1,
  // Response channel
  output logic [1:0]    o_rsp_valid,
  input  logic [1:0]    i_rsp_ready,
  output logic [DW-1:0] o_rsp_result,
  output logic          o_rsp_zero,
  // ALU interface
  output logic [DW-1:0] o_alu_srcA,
  output logic [DW-1:0] o_alu_srcB,
  output logic [2:0]    o_alu_control,
  input  logic [DW-1:0] i_alu_result,
  input  logic          i_alu_zero
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StHold = 2'd2
  } state_e;

  state_e r_state;
  state_e w_state_next;

  // Operand and response registers
  logic [2:0]    r_op;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic          r_owner;
  logic [DW-1:0] r_result;
  logic          r_zero;
  logic [1:0]    r_rsp_valid;

  // Arbitration
  logic          w_grant_any;
  logic          w_grant_port;
  logic          w_accept;
  logic          w_rsp_done;

  // Payload of the granted port
  logic [2:0]    w_sel_op;
  logic [DW-1:0] w_sel_a;
  logic [DW-1:0] w_sel_b;

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Last-grant pointer; a tie goes to the other port.
  logic          r_ptr;
`endif

  // --------------------------------------------------------------------------
  // Grant selection. Only looks at req_valid and the pointer, never at any
  // response-side signal, so req_ready has no path from rsp_ready.
  // --------------------------------------------------------------------------
  always_comb begin
    w_grant_any  = |i_req_valid;
    w_grant_port = 1'b0;
    case (i_req_valid)
      2'b01:   w_grant_port = 1'b0;
      2'b10:   w_grant_port = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
      2'b11:   w_grant_port = 1'b0;
`else
      2'b11:   w_grant_port = ~r_ptr;
`endif
      default: w_grant_port = 1'b0;
    endcase
  end

  // A grant is only ever given to a valid port, so ready implies valid here.
  assign w_accept   = (r_state == StIdle) && w_grant_any;
  assign w_rsp_done = (r_state == StHold) && i_rsp_ready[r_owner];

  always_comb begin
    w_sel_op = w_grant_port ? i_req_op1 : i_req_op0;
    w_sel_a  = w_grant_port ? i_req_a1  : i_req_a0;
    w_sel_b  = w_grant_port ? i_req_b1  : i_req_b0;
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_next = StExec;
        end
      end
      StExec: begin
        // Single-cycle ALU: the result is valid by the end of this cycle.
        w_state_next = StHold;
      end
      StHold: begin
        if (w_rsp_done) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    o_req_ready = 2'b00;
    if (w_accept) begin
      o_req_ready = w_grant_port ? 2'b10 : 2'b01;
    end
    // The operand registers feed the ALU permanently; they only change on
    // accept, so the ALU inputs hold their last values outside EXEC.
    o_alu_srcA    = r_a;
    o_alu_srcB    = r_b;
    o_alu_control = r_op;
    o_rsp_valid   = r_rsp_valid;
    o_rsp_result  = r_result;
    o_rsp_zero    = r_zero;
  end

  // --------------------------------------------------------------------------
  // Operand capture and ownership
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op    <= 3'b000;
      r_a     <= '0;
      r_b     <= '0;
      r_owner <= 1'b0;
    end else if (w_accept) begin
      r_op    <= w_sel_op;
      r_a     <= w_sel_a;
      r_b     <= w_sel_b;
      r_owner <= w_grant_port;
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= 1'b1;
    end else if (w_accept) begin
      r_ptr <= w_grant_port;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Response registers. Result/zero are captured once at the end of EXEC and
  // then stay stable through HOLD regardless of what the ALU does.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (r_state == StExec) begin
      r_result <= i_alu_result;
      r_zero   <= i_alu_zero;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_valid <= 2'b00;
    end else if (r_state == StExec) begin
      r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
    end else if (w_rsp_done) begin
      r_rsp_valid <= 2'b00;
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// ----------------------------------------------------------------------------
// tb_alu_share_arb
//
// Directed bench for alu_share_arb. A small behavioural ALU sits on the
// alu_* interface. A table of single-port operations is run first, followed
// by hand-written sequences for tie-breaking, response back-pressure and
// reset during EXEC. Build with +define+ALU_ARB_FIXED_PRIO_EN to check the
// fixed-priority variant.
// ----------------------------------------------------------------------------
module tb_alu_share_arb;

  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [2:0]    req_op0, req_op1;
  logic [DW-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [DW-1:0] rsp_result;
  logic          rsp_zero;
  logic [DW-1:0] alu_srcA, alu_srcB;
  logic [2:0]    alu_control;
  logic [DW-1:0] alu_result;
  logic          alu_zero;

  int checks   = 0;
  int failures = 0;

  alu_share_arb #(.DW(DW)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_op0     (req_op0),
    .i_req_op1     (req_op1),
    .i_req_a0      (req_a0),
    .i_req_b0      (req_b0),
    .i_req_a1      (req_a1),
    .i_req_b1      (req_b1),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_rsp_result  (rsp_result),
    .o_rsp_zero    (rsp_zero),
    .o_alu_srcA    (alu_srcA),
    .o_alu_srcB    (alu_srcB),
    .o_alu_control (alu_control),
    .i_alu_result  (alu_result),
    .i_alu_zero    (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: unsigned SLT, unknown opcodes return 0.
  always_comb begin
    case (alu_control)
      3'b010:  alu_result = alu_srcA + alu_srcB;
      3'b110:  alu_result = alu_srcA - alu_srcB;
      3'b000:  alu_result = alu_srcA & alu_srcB;
      3'b001:  alu_result = alu_srcA | alu_srcB;
      3'b111:  alu_result = (alu_srcA < alu_srcB) ? 32'd1 : 32'd0;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  typedef struct {
    logic        port;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    string       name;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic port, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    if (port) begin
      req_op1 = op; req_a1 = a; req_b1 = b;
    end else begin
      req_op0 = op; req_a0 = a; req_b0 = b;
    end
    req_valid[port] = 1'b1;
  endtask

  // Bounded wait for any req_ready bit; timeout counts as a failed check.
  task automatic wait_ready(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (req_ready != 2'b00) ok = 1'b1;
      else step();
    end
    if (!ok) chk({name, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_req_ready"},   {30'd0, req_ready}, 32'd0);
    chk({tag, "_rsp_valid"},   {30'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_result"},  rsp_result,         32'd0);
    chk({tag, "_rsp_zero"},    {31'd0, rsp_zero},  32'd0);
    chk({tag, "_alu_srcA"},    alu_srcA,           32'd0);
    chk({tag, "_alu_srcB"},    alu_srcB,           32'd0);
    chk({tag, "_alu_control"}, {29'd0, alu_control}, 32'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  // One complete operation on one port with rsp_ready held high.
  task automatic run_vec(input vec_t v);
    rsp_ready = 2'b11;
    set_req(v.port, v.op, v.a, v.b);
    #1;
    wait_ready(v.name);
    chk({v.name, "_req_ready"}, {30'd0, req_ready}, {30'd0, oh(v.port)});
    step();                                      // accept edge N, now in EXEC
    req_valid = 2'b00;
    chk({v.name, "_exec_ctrl"}, {29'd0, alu_control}, {29'd0, v.op});
    chk({v.name, "_exec_rsp_valid"}, {30'd0, rsp_valid}, 32'd0);
    step();                                      // edge N+1, HOLD
    chk({v.name, "_rsp_valid"}, {30'd0, rsp_valid}, {30'd0, oh(v.port)});
    chk({v.name, "_result"}, rsp_result, v.res);
    chk({v.name, "_zero"}, {31'd0, rsp_zero}, {31'd0, v.zero});
    step();                                      // edge N+2, handshake done
    chk({v.name, "_rsp_done"}, {30'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    logic exp_port;

    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_op0 = 3'b000; req_op1 = 3'b000;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;

    vecs[0] = '{1'b0, 3'b010, 32'd7,          32'd5,          32'd12,         1'b0, "add_7_5"};
    vecs[1] = '{1'b1, 3'b110, 32'd9,          32'd9,          32'd0,          1'b1, "sub_zero"};
    vecs[2] = '{1'b0, 3'b101, 32'h1234,       32'd5,          32'd0,          1'b1, "illegal_101"};
    vecs[3] = '{1'b1, 3'b000, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0, "and"};
    vecs[4] = '{1'b0, 3'b001, 32'd4,          32'd2,          32'd6,          1'b0, "or"};
    vecs[5] = '{1'b1, 3'b111, 32'd3,          32'd8,          32'd1,          1'b0, "slt_true"};
    vecs[6] = '{1'b0, 3'b111, 32'd8,          32'd3,          32'd0,          1'b1, "slt_false"};
    vecs[7] = '{1'b1, 3'b110, 32'd5,          32'd7,          32'hFFFF_FFFE,  1'b0, "sub_neg"};
    vecs[8] = '{1'b0, 3'b010, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, "add_wrap"};
    vecs[9] = '{1'b1, 3'b111, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, "slt_unsigned"};

    // Reset state
    #2;
    check_reset_state("reset");
    step();
    rst_n = 1'b1;
    #1;

    // Table-driven single-port operations
    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i]);
    end

    // Tie-breaking with persistent requests on both ports, from a fresh reset
    apply_reset();
    rsp_ready = 2'b11;
    set_req(1'b0, 3'b010, 32'd1, 32'd1);
    set_req(1'b1, 3'b001, 32'd4, 32'd2);
    #1;
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_port = 1'b0;
`else
      exp_port = k[0];
`endif
      wait_ready("tie");
      chk($sformatf("tie%0d_grant", k), {30'd0, req_ready}, {30'd0, oh(exp_port)});
      step();
      step();
      chk($sformatf("tie%0d_rsp_valid", k), {30'd0, rsp_valid}, {30'd0, oh(exp_port)});
      chk($sformatf("tie%0d_result", k), rsp_result, exp_port ? 32'd6 : 32'd2);
      step();
    end
    req_valid = 2'b00;
    step();

    // Response back-pressure: port 0 SLT stalls, port 1 must wait
    rsp_ready = 2'b10;
    set_req(1'b0, 3'b111, 32'd3, 32'd8);
    #1;
    wait_ready("bp");
    chk("bp_grant", {30'd0, req_ready}, 32'd1);
    step();                                      // EXEC
    req_valid[0] = 1'b0;
    set_req(1'b1, 3'b010, 32'd10, 32'd20);
    #1;
    chk("bp_exec_ready", {30'd0, req_ready}, 32'd0);
    step();                                      // HOLD
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_rsp_valid", c), {30'd0, rsp_valid}, 32'd1);
      chk($sformatf("bp%0d_result", c), rsp_result, 32'd1);
      chk($sformatf("bp%0d_zero", c), {31'd0, rsp_zero}, 32'd0);
      chk($sformatf("bp%0d_req_ready", c), {30'd0, req_ready}, 32'd0);
      step();
    end
    rsp_ready = 2'b11;
    step();                                      // first IDLE cycle after release
    chk("bp_release_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("bp_release_grant", {30'd0, req_ready}, 32'd2);
    step();                                      // EXEC for port 1
    req_valid = 2'b00;
    step();
    chk("bp_p1_rsp_valid", {30'd0, rsp_valid}, 32'd2);
    chk("bp_p1_result", rsp_result, 32'd30);
    step();

    // Reset while in EXEC
    set_req(1'b0, 3'b010, 32'd7, 32'd5);
    #1;
    wait_ready("rst_exec");
    step();                                      // EXEC
    req_valid = 2'b00;
    chk("rst_exec_ctrl", {29'd0, alu_control}, 32'd2);
    rst_n = 1'b0;
    #1;
    check_reset_state("rst_exec");
    step();
    step();
    rst_n = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("rst_exec_no_rsp%0d", c), {30'd0, rsp_valid}, 32'd0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
